// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph constants, converter states and the decimal range helper
// shared by the seven-segment scan driver and its glyph decoder.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;
   // {a,b,c,d,e,f,g}, active-high
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
   };

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

   function automatic logic [63:0] dec_max(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: maps one BCD nibble to an active-high segment pattern;
// dash wins over blank, and non-decimal nibbles show as blank.
module seg7_glyph
   import seg7_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   input  logic       dash_i,
   output logic [6:0] glyph_o
);

   always_comb
      glyph_o = dash_i ? SEG_DASH : (blank_i || digit_i > 4'd9) ? SEG_BLANK : SEG_DIGIT[digit_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: binary-to-BCD double-dabble converter feeding a guarded
// multiplexed N-digit seven-segment scan with blanking, dp mask and overflow dash.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int VAL_W      = 14,
   parameter int DWELL      = 4,
   parameter int GUARD      = 2,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic [VAL_W-1:0]      value,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   input  logic                  blank_lz,
   output logic                  busy,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp
);

   localparam int BCD_W    = 4 * NUM_DIGITS;
   localparam int SLOT_LEN = GUARD + DWELL;
   localparam int SW       = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int PW       = $clog2(SLOT_LEN);
   localparam int CW       = VAL_W > 1 ? $clog2(VAL_W) : 1;

   conv_state_t     state_q;
   logic [VAL_W-1:0] bin_q;
   logic [BCD_W-1:0] bcd_q, bcd_d, disp_q;
   logic [CW-1:0]   cnt_q;
   logic            ovf_q, disp_ovf_q, busy_q;

   always_comb begin
      bcd_d = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++)
         bcd_d[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
   end

   // The range seed and the shifted-out top bit both mark an overflow.
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         disp_q     <= '0;
         disp_ovf_q <= 1'b0;
      end else
         case (state_q)
            IDLE:
               if (load) begin
                  state_q <= SHIFT;
                  bin_q   <= value;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  ovf_q   <= 64'(value) > dec_max(NUM_DIGITS);
                  busy_q  <= 1'b1;
               end
            SHIFT: begin
               {bcd_q, bin_q} <= {bcd_d[BCD_W-2:0], bin_q, 1'b0};
               ovf_q          <= ovf_q | bcd_d[BCD_W-1];
               cnt_q          <= cnt_q + 1'b1;
               if (cnt_q == CW'(VAL_W - 1)) state_q <= COMMIT;
            end
            COMMIT: begin
               disp_q     <= bcd_q;
               disp_ovf_q <= ovf_q;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

   logic [SW-1:0]         slot_q, slot_d;
   logic [PW-1:0]         phase_q, phase_d;
   logic [NUM_DIGITS-1:0] an_q;
   logic [6:0]            seg_q, glyph;
   logic                  dp_q, nz, lz_blank, last_phase;
   logic [3:0]            digit;

   assign last_phase = phase_q == PW'(SLOT_LEN - 1);
   assign phase_d    = last_phase ? '0 : phase_q + 1'b1;
   assign slot_d     = !last_phase ? slot_q : slot_q == SW'(NUM_DIGITS - 1) ? '0 : slot_q + 1'b1;
   assign digit      = disp_q[4*slot_q +: 4];

   always_comb begin
      nz = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (i >= int'(slot_q) && disp_q[4*i +: 4] != 4'd0) nz = 1'b1;
   end

   assign lz_blank = blank_lz && slot_q != '0 && !nz;

   seg7_glyph u_glyph (
      .digit_i (digit),
      .blank_i (lz_blank),
      .dash_i  (disp_ovf_q),
      .glyph_o (glyph)
   );

   // Segments latch during the first guard cycle, so a commit cannot tear a lit digit.
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         slot_q  <= '0;
         phase_q <= '0;
         an_q    <= {NUM_DIGITS{ACTIVE_LOW}};
         seg_q   <= {7{ACTIVE_LOW}};
         dp_q    <= ACTIVE_LOW;
      end else begin
         slot_q  <= slot_d;
         phase_q <= phase_d;
         an_q    <= (int'(phase_d) >= GUARD ? NUM_DIGITS'(1) << slot_d : '0) ^ {NUM_DIGITS{ACTIVE_LOW}};
         if (phase_q == '0) begin
            seg_q <= glyph ^ {7{ACTIVE_LOW}};
            dp_q  <= (dp_mask[slot_q] && !disp_ovf_q) ^ ACTIVE_LOW;
         end
      end

   assign busy = busy_q;
   assign an   = an_q;
   assign seg  = seg_q;
   assign dp   = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: arithmetic reference model of the display checked every
// cycle, plus literal expectations for reset, timing, overflow, abort and dp.
module tb_seg7_scan_driver;

   localparam int N  = 4;
   localparam int VW = 14;
   localparam int DW = 3;
   localparam int GD = 1;
   localparam int P  = GD + DW;

   logic          CLK = 1'b0, RST = 1'b1, load = 1'b0, blank_lz = 1'b0;
   logic [VW-1:0] value = '0;
   logic [N-1:0]  dp_mask = '0;
   logic          busy, dp;
   logic [N-1:0]  an;
   logic [6:0]    seg;

   seg7_scan_driver #(.NUM_DIGITS(N), .VAL_W(VW), .DWELL(DW), .GUARD(GD), .ACTIVE_LOW(1'b1)) dut (
      .CLK(CLK), .RST(RST), .load(load), .value(value), .dp_mask(dp_mask), .blank_lz(blank_lz),
      .busy(busy), .an(an), .seg(seg), .dp(dp)
   );

   always #5 CLK = ~CLK;

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // active-high glyphs 0..9, {a..g}
   localparam logic [6:0] GL [0:9] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

   int   m_pos, m_disp, m_val, m_left;
   bit   m_busy, m_ovf;
   logic [6:0] m_seg;
   logic m_dp;

   function automatic logic [7:0] expect_slot(input int k);
      int pw = 1, upper;
      logic [6:0] g;
      for (int i = 0; i < k; i++) pw *= 10;
      upper = m_disp / pw;
      if (m_ovf) return {~7'h01, 1'b1};
      g = (blank_lz && k > 0 && upper == 0) ? 7'h00 : GL[upper % 10];
      return {~g, ~dp_mask[k]};
   endfunction

   always @(posedge CLK or posedge RST)
      if (RST) begin
         m_pos <= 0; m_busy <= 1'b0; m_left <= 0; m_disp <= 0; m_ovf <= 1'b0;
         m_seg <= 7'h7F; m_dp <= 1'b1;
      end else begin
         if (m_pos % P == 0) {m_seg, m_dp} <= expect_slot((m_pos / P) % N);
         m_pos <= m_pos + 1;
         if (!m_busy && load) begin
            m_busy <= 1'b1; m_left <= VW + 1; m_val <= int'(value);
         end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 1'b0; m_disp <= m_val; m_ovf <= m_val > 9999;
            end
         end
      end

   always @(negedge CLK) begin
      logic [N-1:0] exp_an;
      exp_an = (m_pos % P) < GD ? 4'hF : ~(4'b1 << ((m_pos / P) % N));
      check("model_an", 32'(an), 32'(exp_an));
      check("model_seg", 32'(seg), 32'(m_seg));
      check("model_dp", 32'(dp), 32'(m_dp));
      check("model_busy", 32'(busy), 32'(m_busy));
   end

   task automatic settle();
      repeat (2 * N * P) @(negedge CLK);
   endtask

   task automatic see_digit(input int k, input logic [6:0] es, input logic ed, input string name);
      int t = 0;
      while (an !== ~(4'b1 << k) && t < 40) begin
         @(negedge CLK);
         t++;
      end
      check({name, "_found"}, 32'(t < 40), 32'd1);
      check({name, "_seg"}, 32'(seg), 32'(es));
      check({name, "_dp"}, 32'(dp), 32'(ed));
   endtask

   task automatic load_wait(input int v, output int lat);
      load = 1'b1;
      value = VW'(v);
      lat = 0;
      do begin
         @(negedge CLK);
         load = 1'b0;
         lat++;
      end while (busy !== 1'b0 && lat < 60);
   endtask

   localparam logic [3:0] SCAN_SEQ [0:15] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                              4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

   initial begin
      int lat, falls;
      logic prev;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (10) @(negedge CLK);
      // async reset mid-scan
      @(posedge CLK);
      #3 RST = 1'b1;
      #1;
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("scan_seq", 32'(an), 32'(SCAN_SEQ[i]));
         if (i == 1) check("first_digit0", 32'(seg), 32'h01);
         @(negedge CLK);
      end
      // basic conversion
      blank_lz = 1'b1;
      load_wait(17, lat);
      check("latency_17", 32'(lat), 32'd16);
      settle();
      see_digit(0, 7'b0001111, 1'b1, "v17_d0");
      see_digit(1, 7'b1001111, 1'b1, "v17_d1");
      see_digit(2, 7'b1111111, 1'b1, "v17_d2");
      see_digit(3, 7'b1111111, 1'b1, "v17_d3");
      // overflow then max in-range
      dp_mask = 4'hF;
      load_wait(10000, lat);
      settle();
      for (int k = 0; k < N; k++) see_digit(k, 7'b1111110, 1'b1, "ovf");
      load_wait(9999, lat);
      settle();
      for (int k = 0; k < N; k++) see_digit(k, 7'b0000100, 1'b0, "nines");
      // load while busy
      dp_mask = '0;
      load = 1'b1;
      value = VW'(123);
      falls = 0;
      prev = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         load = (i == 2);
         if (i == 2) value = VW'(42);
         if (prev && !busy) falls++;
         prev = busy;
      end
      check("busy_falls", 32'(falls), 32'd1);
      settle();
      see_digit(0, 7'b0000110, 1'b1, "v123_d0");
      see_digit(1, 7'b0010010, 1'b1, "v123_d1");
      see_digit(2, 7'b1001111, 1'b1, "v123_d2");
      see_digit(3, 7'b1111111, 1'b1, "v123_d3");
      // abort mid-shift
      load = 1'b1;
      value = VW'(555);
      @(negedge CLK);
      load = 1'b0;
      repeat (4) @(negedge CLK);
      #2 RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      settle();
      see_digit(0, 7'b0000001, 1'b1, "abort_d0");
      see_digit(1, 7'b1111111, 1'b1, "abort_d1");
      // dp on a blanked digit
      dp_mask = 4'b0100;
      load_wait(5, lat);
      settle();
      see_digit(2, 7'b1111111, 1'b0, "dp_d2");
      see_digit(0, 7'b0100100, 1'b1, "dp_d0");
      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         load = $urandom_range(0, 7) == 0;
         value = VW'($urandom_range(0, 4) == 0 ? $urandom_range(10000, 16383) : $urandom_range(0, 9999));
         if ($urandom_range(0, 15) == 0) dp_mask = N'($urandom);
         if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
         @(negedge CLK);
      end
      load = 1'b0;
      settle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
